// File: rtl/scaler_pkg.sv
// Shared scaler definitions: widths, unity scale constant and the phase-accumulator step
// used by both the input and output sides of the scaler.
package scaler_pkg;

    localparam int DW = 24;
    localparam int CW = 10;
    localparam int AW = 11;
    localparam int KW = 8;

    localparam logic [KW-1:0] K_ONE = 8'h40;

    // Returns {sel, accNext}. k==0 never selects; k>=1.0 always selects and leaves acc alone.
    function automatic logic [KW:0] sel_step(input logic [KW-1:0] acc, input logic [KW-1:0] k);
        logic [KW:0] sum;
        logic [KW:0] res;
        sum = {1'b0, acc} + {1'b0, k};
        if (k == '0) begin
            res = {1'b0, acc};
        end else if (k >= K_ONE) begin
            res = {1'b1, acc};
        end else if (sum >= {1'b0, K_ONE}) begin
            res = {1'b1, sum[KW-1:0] - K_ONE};
        end else begin
            res = {1'b0, sum[KW-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/input_ctrl_phase_acc.sv
// Decimation phase accumulator: reports whether the current sample is kept and
// advances on step. A clear returns it to the frame/line start phase (1.0 - k).
module input_ctrl_phase_acc
    import scaler_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [KW-1:0] k,
    input  logic          clr,
    input  logic          step,
    output logic          sel
);

    logic [KW-1:0] acc;
    logic [KW-1:0] accCur;
    logic [KW-1:0] accNext;
    logic          fresh;

    // The start phase depends on k, so it is applied through a flag rather than a reset value.
    assign accCur         = fresh ? (K_ONE - k) : acc;
    assign {sel, accNext} = sel_step(accCur, k);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            fresh <= 1'b1;
        end else if (clr) begin
            acc   <= '0;
            fresh <= 1'b1;
        end else if (step) begin
            acc   <= accNext;
            fresh <= 1'b0;
        end
    end

endmodule

// File: rtl/input_ctrl.sv
// Scaler input side: tracks raster position, crops and decimates the pixel stream, and
// writes surviving pixels into the ping-pong line buffer with a line-complete pulse.
module input_ctrl
    import scaler_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          En,
    input  logic          dInEn,
    input  logic [DW-1:0] dIn,
    input  logic [CW-1:0] inXRes,
    input  logic [CW-1:0] xBgn,
    input  logic [CW-1:0] xEnd,
    input  logic [CW-1:0] yBgn,
    input  logic [CW-1:0] yEnd,
    input  logic [KW-1:0] kX,
    input  logic [KW-1:0] kY,
    input  logic [2:0]    fifoNum,
    output logic [AW-1:0] ramWrtAddr,
    output logic          ramWrtEn,
    output logic [DW-1:0] dataOut,
    output logic          jmp,
    output logic          h_valid,
    output logic          v_valid
);

    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] col;
    logic          bank;
    logic          lineKeep;

    logic          valid;
    logic [CW-1:0] xMax;
    logic [CW-1:0] xLast;
    logic          xWrap;
    logic          xZero;
    logic          hin;
    logic          vin;
    logic          xSel;
    logic          ySel;
    logic          lineOk;
    logic          wr;
    logic          lineEnd;

    assign valid = En & dInEn;
    assign xMax  = inXRes - CW'(1);
    assign xLast = (xEnd >= xMax) ? xMax : xEnd;
    assign xWrap = (x == xMax);
    assign xZero = (x == '0);
    assign hin   = (x >= xBgn) && (x <= xEnd);
    assign vin   = (y >= yBgn) && (y <= yEnd);

    // The line decision is made at x==0 and must already apply to that same pixel.
    assign lineOk  = xZero ? (vin & ySel & (fifoNum != '0)) : lineKeep;
    assign wr      = valid & hin & vin & xSel & lineOk;
    assign lineEnd = valid & hin & vin & lineOk & (x == xLast);

    input_ctrl_phase_acc uAccX (
        .clk  (clk),
        .rst  (rst),
        .k    (kX),
        .clr  (~En | (valid & xWrap)),
        .step (valid & hin & vin),
        .sel  (xSel)
    );

    input_ctrl_phase_acc uAccY (
        .clk  (clk),
        .rst  (rst),
        .k    (kY),
        .clr  (~En),
        .step (valid & vin & xZero),
        .sel  (ySel)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x          <= '0;
            y          <= '0;
            col        <= '0;
            bank       <= 1'b0;
            lineKeep   <= 1'b0;
            ramWrtAddr <= '0;
            ramWrtEn   <= 1'b0;
            dataOut    <= '0;
            jmp        <= 1'b0;
            h_valid    <= 1'b0;
            v_valid    <= 1'b0;
        end else if (!En) begin
            x        <= '0;
            y        <= '0;
            col      <= '0;
            lineKeep <= 1'b0;
            ramWrtEn <= 1'b0;
            jmp      <= 1'b0;
            h_valid  <= 1'b0;
            v_valid  <= 1'b0;
        end else begin
            ramWrtEn <= wr;
            jmp      <= lineEnd;
            h_valid  <= valid & hin;
            v_valid  <= valid & vin;
            if (wr) begin
                dataOut    <= dIn;
                ramWrtAddr <= {bank, col};
            end
            if (lineEnd) begin
                col  <= '0;
                bank <= ~bank;
            end else if (wr) begin
                col <= col + CW'(1);
            end
            if (valid) begin
                if (xZero) begin
                    lineKeep <= vin & ySel & (fifoNum != '0);
                end
                if (xWrap) begin
                    x <= '0;
                    if (y != '1) begin
                        y <= y + CW'(1);
                    end
                end else begin
                    x <= x + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_input_ctrl.sv
// Scoreboard bench for input_ctrl: a raster-level reference model queues expected writes,
// a monitor pops and compares them whenever the DUT writes or signals a line end.
module tb_input_ctrl;
    import scaler_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          En;
    logic          dInEn;
    logic [DW-1:0] dIn;
    logic [CW-1:0] inXRes, xBgn, xEnd, yBgn, yEnd;
    logic [KW-1:0] kX, kY;
    logic [2:0]    fifoNum;
    logic [AW-1:0] ramWrtAddr;
    logic          ramWrtEn;
    logic [DW-1:0] dataOut;
    logic          jmp, h_valid, v_valid;

    always #5 clk = ~clk;

    input_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .En         (En),
        .dInEn      (dInEn),
        .dIn        (dIn),
        .inXRes     (inXRes),
        .xBgn       (xBgn),
        .xEnd       (xEnd),
        .yBgn       (yBgn),
        .yEnd       (yEnd),
        .kX         (kX),
        .kY         (kY),
        .fifoNum    (fifoNum),
        .ramWrtAddr (ramWrtAddr),
        .ramWrtEn   (ramWrtEn),
        .dataOut    (dataOut),
        .jmp        (jmp),
        .h_valid    (h_valid),
        .v_valid    (v_valid)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          jmp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   nWr = 0;
    int   nJmp = 0;
    int   mx = 0, my = 0, mcol = 0, mbank = 0;
    bit   mkeep = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample i of a decimated run is kept when floor(i*k/64) steps, the first always.
    function automatic bit selIdx(input int i, input int k);
        if (k == 0) return 1'b0;
        if (k >= 64) return 1'b1;
        if (i == 0) return 1'b1;
        return ((i * k) / 64) != (((i - 1) * k) / 64);
    endfunction

    task automatic modelPixel(input logic [DW-1:0] d, input int f);
        int   xr, xl;
        bit   hin, vin, wr, je;
        exp_t e;
        xr  = int'(inXRes);
        xl  = (int'(xEnd) >= xr - 1) ? xr - 1 : int'(xEnd);
        hin = (mx >= int'(xBgn)) && (mx <= int'(xEnd));
        vin = (my >= int'(yBgn)) && (my <= int'(yEnd));
        if (mx == 0) mkeep = vin && selIdx(my - int'(yBgn), int'(kY)) && (f != 0);
        wr = hin && vin && mkeep && selIdx(mx - int'(xBgn), int'(kX));
        je = hin && vin && mkeep && (mx == xl);
        if (wr || je) begin
            e.we   = wr;
            e.addr = {mbank[0], mcol[CW-1:0]};
            e.data = d;
            e.jmp  = je;
            q.push_back(e);
        end
        if (je) begin
            mcol  = 0;
            mbank = mbank ^ 1;
        end else if (wr) begin
            mcol++;
        end
        if (mx == xr - 1) begin
            mx = 0;
            if (my < 1023) my++;
        end else begin
            mx++;
        end
    endtask

    task automatic drive(input logic e, input logic v, input logic [DW-1:0] d, input int f);
        @(posedge clk);
        #1;
        En      = e;
        dInEn   = v;
        dIn     = d;
        fifoNum = f[2:0];
        if (!e) begin
            mx   = 0;
            my   = 0;
            mcol = 0;
        end else if (v) begin
            modelPixel(d, f);
        end
    endtask

    task automatic cfg(input int xr, input int xb, input int xe, input int yb, input int ye,
                       input int kx, input int ky);
        inXRes = xr[CW-1:0];
        xBgn   = xb[CW-1:0];
        xEnd   = xe[CW-1:0];
        yBgn   = yb[CW-1:0];
        yEnd   = ye[CW-1:0];
        kX     = kx[KW-1:0];
        kY     = ky[KW-1:0];
    endtask

    task automatic newFrame();
        drive(1'b0, 1'b0, '0, 4);
        nWr  = 0;
        nJmp = 0;
    endtask

    task automatic drain(input string name);
        drive(1'b1, 1'b0, '0, 4);
        drive(1'b1, 1'b0, '0, 4);
        @(negedge clk);
        #2;
        chk({name, "_drained"}, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && (ramWrtEn || jmp)) begin
            exp_t e;
            if (ramWrtEn) nWr++;
            if (jmp) nJmp++;
            if (q.size() == 0) begin
                chk("spurious_output", {ramWrtEn, jmp}, 0);
            end else begin
                e = q.pop_front();
                chk("wr_en", ramWrtEn, e.we);
                chk("jmp", jmp, e.jmp);
                if (e.we) begin
                    chk("addr", ramWrtAddr, e.addr);
                    chk("data", dataOut, e.data);
                end
                chk("h_valid", h_valid, 1);
                chk("v_valid", v_valid, 1);
            end
        end
    end

    initial begin
        rst = 1'b0;
        En = 1'b0;
        dInEn = 1'b0;
        dIn = '0;
        fifoNum = 3'd4;
        cfg(3, 0, 2, 0, 2, 'h20, 'h20);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", ramWrtEn, 0);
        chk("rst_jmp", jmp, 0);
        chk("rst_addr", ramWrtAddr, 0);
        chk("rst_data", dataOut, 0);
        chk("rst_hv", {h_valid, v_valid}, 0);
        rst = 1'b1;

        // 2:1 both ways: pixels 0,2 of lines 0,2
        newFrame();
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, DW'(i + 1), 4);
        drain("s1");
        chk("s1_writes", nWr, 4);
        chk("s1_jmps", nJmp, 2);

        // unity scale: every pixel written
        cfg(3, 0, 2, 0, 2, 'h40, 'h40);
        newFrame();
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, DW'(i + 'h100), 4);
        drain("s2");
        chk("s2_writes", nWr, 9);
        chk("s2_jmps", nJmp, 3);

        // single-pixel window
        cfg(3, 1, 1, 1, 1, 'h40, 'h40);
        newFrame();
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, DW'(i + 'h200), 4);
        drain("s3");
        chk("s3_writes", nWr, 1);
        chk("s3_jmps", nJmp, 1);

        // first line dropped for lack of a free buffer
        cfg(3, 0, 2, 0, 2, 'h40, 'h40);
        newFrame();
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, DW'(i + 'h300), (i < 3) ? 0 : 1);
        drain("s4");
        chk("s4_writes", nWr, 6);
        chk("s4_jmps", nJmp, 2);

        // valid toggling each clock
        cfg(3, 0, 2, 0, 2, 'h20, 'h20);
        newFrame();
        for (int i = 0; i < 18; i++) drive(1'b1, (i % 2) == 0, DW'(i + 'h400), 4);
        drain("s5");
        chk("s5_writes", nWr, 4);
        chk("s5_jmps", nJmp, 2);

        // empty windows
        cfg(4, 3, 1, 0, 3, 'h40, 'h40);
        newFrame();
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, DW'(i), 4);
        drain("s_emptyx");
        chk("emptyx_writes", nWr, 0);

        // randomized frames
        for (int r = 0; r < 24; r++) begin
            int ks[8] = '{0, 'h10, 'h18, 'h20, 'h30, 'h40, 'h55, 'h80};
            cfg($urandom_range(1, 8), $urandom_range(0, 9), $urandom_range(0, 9),
                $urandom_range(0, 5), $urandom_range(0, 6),
                ks[$urandom_range(0, 7)], ks[$urandom_range(0, 7)]);
            newFrame();
            for (int c = 0; c < 60; c++)
                drive(1'b1, ($urandom % 4) != 0, DW'($urandom), $urandom_range(0, 3));
            drain("rand");
        end

        // reset pulled mid-line while a write is showing
        cfg(4, 0, 3, 0, 3, 'h40, 'h40);
        newFrame();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, DW'(i + 'h500), 4);
        @(posedge clk);
        #1;
        dInEn = 1'b0;
        @(negedge clk);
        #2;
        chk("s6_pre_wr_en", ramWrtEn, 1);
        rst = 1'b0;
        #1;
        chk("s6_wr_en", ramWrtEn, 0);
        chk("s6_jmp", jmp, 0);
        chk("s6_addr", ramWrtAddr, 0);
        chk("s6_data", dataOut, 0);
        chk("s6_hv", {h_valid, v_valid}, 0);
        mx = 0;
        my = 0;
        mcol = 0;
        mbank = 0;
        q.delete();
        #2;
        rst = 1'b1;
        nWr = 0;
        nJmp = 0;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, DW'(i + 'h600), 4);
        drain("s6");
        chk("s6_writes", nWr, 4);
        chk("s6_jmps", nJmp, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
